// File: rtl/doodle_pkg.sv
// Shared types and constants for the doodle game datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package doodle_pkg;

  localparam int PLATFORM_NUM = 8;

  typedef logic [9:0] coord_t;
  typedef coord_t [0:PLATFORM_NUM-1] coord_arr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } coll_state_t;

  // Game-state code in which collision scanning runs.
  localparam logic [7:0] PLAY_STATE = 8'd1;

endpackage

// File: rtl/platform_hit_check.sv
// Landing test of the doodle against a single platform.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the output follows the inputs.
//
// Ports:
//   plat_x, plat_y           platform left X / top Y
//   doodle_x, doodle_y       doodle left X / top Y
//   doodle_y_motion          doodle Y step, two's complement, positive = falling
//   hit                      doodle is falling and its feet sit on this platform
module platform_hit_check
  import doodle_pkg::*;
#(
  parameter int PLATFORM_W = 60,
  parameter int DOODLE_W   = 20,
  parameter int DOODLE_H   = 20,
  parameter int LAND_TOL   = 4
) (
  input  logic [9:0] plat_x,
  input  logic [9:0] plat_y,
  input  logic [9:0] doodle_x,
  input  logic [9:0] doodle_y,
  input  logic [9:0] doodle_y_motion,
  output logic       hit
);

  localparam logic [10:0] PW11  = 11'(PLATFORM_W);
  localparam logic [10:0] DW11  = 11'(DOODLE_W);
  localparam logic [10:0] DH11  = 11'(DOODLE_H);
  localparam logic [10:0] TOL11 = 11'(LAND_TOL);

  logic        falling;
  logic [10:0] feet;
  logic [10:0] py_lo;
  logic [10:0] py_hi;
  logic [10:0] dx_right;
  logic [10:0] px_right;
  logic        y_ok;
  logic        x_ok;

  // All arithmetic is widened to 11 bits so nothing wraps near the 10-bit limit.
  assign falling  = !doodle_y_motion[9] && (doodle_y_motion != 10'd0);
  assign feet     = {1'b0, doodle_y} + DH11;
  assign py_lo    = {1'b0, plat_y};
  assign py_hi    = {1'b0, plat_y} + TOL11;
  assign dx_right = {1'b0, doodle_x} + DW11;
  assign px_right = {1'b0, plat_x} + PW11;

  assign y_ok = (feet >= py_lo) && (feet <= py_hi);
  assign x_ok = (dx_right > {1'b0, plat_x}) && ({1'b0, doodle_x} < px_right);

  assign hit = falling && y_ok && x_ok;

endmodule

// File: rtl/platform_collision.sv
// Per-frame doodle/platform landing detector: snapshot, scan one platform per clock, report first hit.
// Latency: new-frame edge sampled at cycle 0, land_valid pulses at cycle 9.
// Backpressure: none; new-frame edges arriving while busy are dropped, not queued.
//
// Optional build macro COLLISION_STATS_EN enables the saturating land_count
// counter; without it land_count is tied to zero.
//
// Ports:
//   Clk, Reset_n             clock, async active-low reset
//   frame_clk_edge, state    frame edge code (2'b01 = new frame), game state
//   Platform_X_in/Y_in       8 platform coordinates
//   Doodle_X/Y/Y_motion      doodle position and vertical step
//   land_valid/hit/idx/Y     scan result (pulse + held result)
//   scan_busy, land_count    scan in progress, landing counter
module platform_collision
  import doodle_pkg::*;
#(
  parameter int         PLATFORM_W = 60,
  parameter int         DOODLE_W   = 20,
  parameter int         DOODLE_H   = 20,
  parameter int         LAND_TOL   = 4,
  parameter logic [7:0] PLAY_STATE = doodle_pkg::PLAY_STATE
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [1:0]  frame_clk_edge,
  input  logic [7:0]  state,
  input  coord_arr_t  Platform_X_in,
  input  coord_arr_t  Platform_Y_in,
  input  logic [9:0]  Doodle_X,
  input  logic [9:0]  Doodle_Y,
  input  logic [9:0]  Doodle_Y_motion,
  output logic        land_valid,
  output logic        land_hit,
  output logic [2:0]  land_idx,
  output logic [9:0]  land_Y,
  output logic        scan_busy,
  output logic [15:0] land_count
);

  coll_state_t st;

  coord_arr_t  snap_px;
  coord_arr_t  snap_py;
  logic [9:0]  snap_dx;
  logic [9:0]  snap_dy;
  logic [9:0]  snap_dm;
  logic [2:0]  idx;

  logic        found_hit;
  logic [2:0]  found_idx;
  logic [9:0]  found_y;

  logic [9:0]  cur_px;
  logic [9:0]  cur_py;
  logic        cur_hit;

  logic        start;

  assign start  = (frame_clk_edge == 2'b01) && (state == PLAY_STATE);
  assign cur_px = snap_px[idx];
  assign cur_py = snap_py[idx];

  platform_hit_check #(
    .PLATFORM_W (PLATFORM_W),
    .DOODLE_W   (DOODLE_W),
    .DOODLE_H   (DOODLE_H),
    .LAND_TOL   (LAND_TOL)
  ) u_hit (
    .plat_x          (cur_px),
    .plat_y          (cur_py),
    .doodle_x        (snap_dx),
    .doodle_y        (snap_dy),
    .doodle_y_motion (snap_dm),
    .hit             (cur_hit)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      st         <= IDLE;
      snap_px    <= '0;
      snap_py    <= '0;
      snap_dx    <= '0;
      snap_dy    <= '0;
      snap_dm    <= '0;
      idx        <= '0;
      found_hit  <= 1'b0;
      found_idx  <= '0;
      found_y    <= '0;
      land_valid <= 1'b0;
      land_hit   <= 1'b0;
      land_idx   <= '0;
      land_Y     <= '0;
      scan_busy  <= 1'b0;
    end else begin
      land_valid <= 1'b0;
      case (st)
        IDLE: begin
          if (start) begin
            snap_px   <= Platform_X_in;
            snap_py   <= Platform_Y_in;
            snap_dx   <= Doodle_X;
            snap_dy   <= Doodle_Y;
            snap_dm   <= Doodle_Y_motion;
            idx       <= '0;
            found_hit <= 1'b0;
            found_idx <= '0;
            found_y   <= '0;
            scan_busy <= 1'b1;
            st        <= SCAN;
          end
        end
        SCAN: begin
          // Only the lowest-index hit is kept.
          if (cur_hit && !found_hit) begin
            found_hit <= 1'b1;
            found_idx <= idx;
            found_y   <= cur_py;
          end
          if (idx == 3'd7) begin
            st <= DONE;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        DONE: begin
          land_valid <= 1'b1;
          land_hit   <= found_hit;
          land_idx   <= found_idx;
          land_Y     <= found_y;
          scan_busy  <= 1'b0;
          st         <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

`ifdef COLLISION_STATS_EN
  logic [15:0] count_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count_q <= '0;
    end else if ((st == IDLE) && (state == 8'd0)) begin
      count_q <= '0;
    end else if ((st == DONE) && found_hit && (count_q != 16'hFFFF)) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign land_count = count_q;
`else
  assign land_count = 16'd0;
`endif

endmodule

// File: tb/tb_platform_collision.sv
// Directed self-checking bench for platform_collision.
// Latency: expects land_valid 9 cycles after the sampled new-frame edge.
// Backpressure: n/a.
module tb_platform_collision;
  import doodle_pkg::*;

  logic        Clk;
  logic        Reset_n;
  logic [1:0]  frame_clk_edge;
  logic [7:0]  state;
  coord_arr_t  Platform_X_in;
  coord_arr_t  Platform_Y_in;
  logic [9:0]  Doodle_X;
  logic [9:0]  Doodle_Y;
  logic [9:0]  Doodle_Y_motion;
  logic        land_valid;
  logic        land_hit;
  logic [2:0]  land_idx;
  logic [9:0]  land_Y;
  logic        scan_busy;
  logic [15:0] land_count;

  int checks;
  int failures;

  platform_collision dut (
    .Clk             (Clk),
    .Reset_n         (Reset_n),
    .frame_clk_edge  (frame_clk_edge),
    .state           (state),
    .Platform_X_in   (Platform_X_in),
    .Platform_Y_in   (Platform_Y_in),
    .Doodle_X        (Doodle_X),
    .Doodle_Y        (Doodle_Y),
    .Doodle_Y_motion (Doodle_Y_motion),
    .land_valid      (land_valid),
    .land_hit        (land_hit),
    .land_idx        (land_idx),
    .land_Y          (land_Y),
    .scan_busy       (scan_busy),
    .land_count      (land_count)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  // All platforms far below at (0,400), then one platform moved into place.
  task automatic set_field(input int p, input int px, input int py);
    for (int i = 0; i < 8; i++) begin
      Platform_X_in[i] = 10'd0;
      Platform_Y_in[i] = 10'd400;
    end
    if (p >= 0) begin
      Platform_X_in[p] = 10'(px);
      Platform_Y_in[p] = 10'(py);
    end
  endtask

  // Issue one new-frame edge (sampled at posedge k=0) and watch 16 cycles.
  // extra_k >= 1 repeats the edge so that it is sampled at posedge extra_k.
  task automatic run_scan(input int extra_k, output int first_k, output int nvalid,
                          output logic hit, output logic [2:0] idx,
                          output logic [9:0] y, output logic busy_mid);
    first_k  = -1;
    nvalid   = 0;
    hit      = 1'b0;
    idx      = '0;
    y        = '0;
    busy_mid = 1'b0;
    @(negedge Clk);
    frame_clk_edge = 2'b01;
    for (int k = 0; k < 16; k++) begin
      @(posedge Clk);
      #1;
      frame_clk_edge = (k + 1 == extra_k) ? 2'b01 : 2'b00;
      if (k == 4) busy_mid = scan_busy;
      if (land_valid) begin
        nvalid++;
        if (first_k < 0) begin
          first_k = k;
          hit     = land_hit;
          idx     = land_idx;
          y       = land_Y;
        end
      end
    end
  endtask

  task automatic test_reset;
    Reset_n = 1'b0;
    frame_clk_edge = 2'b00;
    state = 8'd1;
    set_field(-1, 0, 0);
    Doodle_X = '0;
    Doodle_Y = '0;
    Doodle_Y_motion = '0;
    repeat (3) @(negedge Clk);
    checks++;
    if ({land_valid, land_hit, land_idx, land_Y, scan_busy, land_count} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got v=%0b h=%0b i=%0d y=%0d b=%0b c=%0d expected all 0",
               land_valid, land_hit, land_idx, land_Y, scan_busy, land_count);
    end
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_basic;
    int k, n; logic h, b; logic [2:0] i; logic [9:0] y;
    set_field(3, 260, 160);
    Doodle_X = 10'd270; Doodle_Y = 10'd140; Doodle_Y_motion = 10'd2;
    run_scan(0, k, n, h, i, y, b);
    checks++;
    if (k !== 9 || n !== 1) begin
      failures++;
      $display("FAIL basic_latency got cycle=%0d pulses=%0d expected cycle=9 pulses=1", k, n);
    end
    checks++;
    if (h !== 1'b1 || i !== 3'd3 || y !== 10'd160) begin
      failures++;
      $display("FAIL basic_result got h=%0b i=%0d y=%0d expected h=1 i=3 y=160", h, i, y);
    end
    checks++;
    if (b !== 1'b1 || scan_busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_busy got mid=%0b end=%0b expected mid=1 end=0", b, scan_busy);
    end
    checks++;
    if (land_hit !== 1'b1 || land_idx !== 3'd3) begin
      failures++;
      $display("FAIL basic_hold got h=%0b i=%0d expected held h=1 i=3", land_hit, land_idx);
    end
  endtask

  task automatic test_rising;
    int k, n; logic h, b; logic [2:0] i; logic [9:0] y;
    set_field(3, 260, 160);
    Doodle_X = 10'd270; Doodle_Y = 10'd140; Doodle_Y_motion = 10'h3FD;
    run_scan(0, k, n, h, i, y, b);
    checks++;
    if (k !== 9 || h !== 1'b0 || i !== 3'd0 || y !== 10'd0) begin
      failures++;
      $display("FAIL rising got cycle=%0d h=%0b i=%0d y=%0d expected cycle=9 h=0 i=0 y=0", k, h, i, y);
    end
    Doodle_Y_motion = 10'd0;
    run_scan(0, k, n, h, i, y, b);
    checks++;
    if (k !== 9 || h !== 1'b0) begin
      failures++;
      $display("FAIL zero_motion got cycle=%0d h=%0b expected cycle=9 h=0", k, h);
    end
  endtask

  task automatic test_tolerance;
    int k, n; logic h, b; logic [2:0] i; logic [9:0] y;
    int dy_tab[3]  = '{144, 145, 139};
    logic exp_tab[3] = '{1'b1, 1'b0, 1'b0};
    set_field(3, 260, 160);
    Doodle_X = 10'd270; Doodle_Y_motion = 10'd2;
    for (int t = 0; t < 3; t++) begin
      Doodle_Y = 10'(dy_tab[t]);
      run_scan(0, k, n, h, i, y, b);
      checks++;
      if (k !== 9 || h !== exp_tab[t]) begin
        failures++;
        $display("FAIL tolerance feet=%0d got cycle=%0d h=%0b expected cycle=9 h=%0b",
                 dy_tab[t] + 20, k, h, exp_tab[t]);
      end
    end
  endtask

  task automatic test_x_edges;
    int k, n; logic h, b; logic [2:0] i; logic [9:0] y;
    int dx_tab[4]  = '{281, 280, 359, 360};
    logic exp_tab[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    set_field(3, 300, 160);
    Doodle_Y = 10'd140; Doodle_Y_motion = 10'd2;
    for (int t = 0; t < 4; t++) begin
      Doodle_X = 10'(dx_tab[t]);
      run_scan(0, k, n, h, i, y, b);
      checks++;
      if (k !== 9 || h !== exp_tab[t]) begin
        failures++;
        $display("FAIL x_edge dx=%0d got cycle=%0d h=%0b expected cycle=9 h=%0b",
                 dx_tab[t], k, h, exp_tab[t]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int k, n; logic h, b; logic [2:0] i; logic [9:0] y;
    set_field(2, 260, 160);
    Platform_X_in[5] = 10'd250;
    Platform_Y_in[5] = 10'd158;
    Doodle_X = 10'd270; Doodle_Y = 10'd140; Doodle_Y_motion = 10'd2;
    run_scan(4, k, n, h, i, y, b);
    checks++;
    if (k !== 9 || n !== 1) begin
      failures++;
      $display("FAIL second_edge got cycle=%0d pulses=%0d expected cycle=9 pulses=1", k, n);
    end
    checks++;
    if (h !== 1'b1 || i !== 3'd2 || y !== 10'd160) begin
      failures++;
      $display("FAIL priority got h=%0b i=%0d y=%0d expected h=1 i=2 y=160", h, i, y);
    end
  endtask

  task automatic test_reset_mid_scan;
    int n; int k; logic h, b; logic [2:0] i; logic [9:0] y;
    set_field(3, 260, 160);
    Doodle_X = 10'd270; Doodle_Y = 10'd140; Doodle_Y_motion = 10'd2;
    n = 0;
    @(negedge Clk);
    frame_clk_edge = 2'b01;
    for (int c = 0; c < 5; c++) begin
      @(posedge Clk);
      #1;
      frame_clk_edge = 2'b00;
    end
    Reset_n = 1'b0;
    #2;
    checks++;
    if ({land_valid, land_hit, land_idx, land_Y, scan_busy, land_count} !== '0) begin
      failures++;
      $display("FAIL mid_reset_outputs got v=%0b h=%0b i=%0d y=%0d b=%0b c=%0d expected all 0",
               land_valid, land_hit, land_idx, land_Y, scan_busy, land_count);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge Clk);
      if (land_valid) n++;
    end
    checks++;
    if (n !== 0) begin
      failures++;
      $display("FAIL mid_reset_pulse got pulses=%0d expected 0", n);
    end
    run_scan(0, k, n, h, i, y, b);
    checks++;
    if (k !== 9 || h !== 1'b1 || i !== 3'd3) begin
      failures++;
      $display("FAIL fresh_scan got cycle=%0d h=%0b i=%0d expected cycle=9 h=1 i=3", k, h, i);
    end
  endtask

  task automatic test_gating;
    int k, n; logic h, b; logic [2:0] i; logic [9:0] y;
    set_field(3, 260, 160);
    Doodle_X = 10'd270; Doodle_Y = 10'd140; Doodle_Y_motion = 10'd2;
    state = 8'd0;
    run_scan(0, k, n, h, i, y, b);
    checks++;
    if (n !== 0 || b !== 1'b0 || scan_busy !== 1'b0) begin
      failures++;
      $display("FAIL gating got pulses=%0d busy=%0b expected pulses=0 busy=0", n, b);
    end
    state = 8'd1;
  endtask

  task automatic test_stats;
    int k, n; logic h, b; logic [2:0] i; logic [9:0] y;
    logic [15:0] exp_cnt;
`ifdef COLLISION_STATS_EN
    exp_cnt = 16'd3;
`else
    exp_cnt = 16'd0;
`endif
    set_field(3, 260, 160);
    Doodle_X = 10'd270; Doodle_Y = 10'd140; Doodle_Y_motion = 10'd2;
    for (int t = 0; t < 3; t++) run_scan(0, k, n, h, i, y, b);
    checks++;
    if (land_count !== exp_cnt) begin
      failures++;
      $display("FAIL land_count got %0d expected %0d", land_count, exp_cnt);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_rising();
    test_tolerance();
    test_x_edges();
    test_back_to_back();
    test_reset_mid_scan();
    test_gating();
    test_stats();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
